// File: rtl/heap_pkg.sv
// ============================================================================
// heap_pkg : shared opcode/state encodings for the array heap
// Revision : 1.0
// ============================================================================
`default_nettype none

package heap_pkg;

  localparam int unsigned c_op_w = 3;

  typedef enum logic [2:0] {
    OP_ALLOC  = 3'd0,
    OP_FREE   = 3'd1,
    OP_READ   = 3'd2,
    OP_WRITE  = 3'd3,
    OP_SIZE   = 3'd4,
    OP_PUSH   = 3'd5,
    OP_POP    = 3'd6,
    OP_RESIZE = 3'd7
  } heap_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } heap_state_e;

endpackage

`default_nettype wire

// File: rtl/heap_ram.sv
// ============================================================================
// heap_ram : single-port synchronous heap storage, one-cycle read, no reset
// Revision : 1.0
// ============================================================================
`default_nettype none

module heap_ram #(
  parameter int unsigned WIDTH  = 12,
  parameter int unsigned DEPTH  = 2000,
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clock,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Read data only moves on an enabled read, so it stays put while a response waits.
  always_ff @(posedge clock) begin
    if (en) begin
      if (we) r_mem[addr] <= wdata;
      else    rdata       <= r_mem[addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/array_heap.sv
// ============================================================================
// array_heap : handle-based array heap with free-list reuse, size tracking,
//              bounds checking and high-water accounting
// Revision   : 1.0
// ============================================================================
`default_nettype none

module array_heap
  import heap_pkg::*;
#(
  parameter  int unsigned MemoryElementWidth = 12,
  parameter  int unsigned NArea              = 10,
  parameter  int unsigned NArrays            = 200,
  localparam int unsigned HW                 = $clog2(NArrays),
  localparam int unsigned IW                 = $clog2(NArea + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [c_op_w-1:0]             req_op,
  input  logic [HW-1:0]                 req_array,
  input  logic [IW-1:0]                 req_index,
  input  logic [MemoryElementWidth-1:0] req_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [MemoryElementWidth-1:0] rsp_data,
  output logic                          rsp_error,
  output logic [HW:0]                   in_use,
  output logic [HW:0]                   allocs
);

  localparam int unsigned c_depth    = NArrays * NArea;
  localparam int unsigned c_aw       = $clog2(c_depth + 1);
  localparam logic [HW:0] c_narrays  = (HW + 1)'(NArrays);
  localparam logic [IW-1:0] c_narea  = IW'(NArea);

  heap_state_e r_state, w_next;

  heap_op_e                    r_op;
  logic [HW-1:0]               r_array;
  logic [IW-1:0]               r_index;
  logic [MemoryElementWidth-1:0] r_data;

  logic                        r_live  [NArrays];
  logic [IW-1:0]               r_size  [NArrays];
  logic [HW-1:0]               r_stack [NArrays];
  logic [HW:0]                 r_top, r_fresh, r_in_use, r_allocs;

  logic [MemoryElementWidth-1:0] r_rsp_data;
  logic                        r_rsp_error, r_use_ram;

  logic                        w_hok, w_live, w_err, w_mem_rd, w_mem_wr;
  logic [HW-1:0]               w_slot, w_sp, w_new_h;
  logic [IW-1:0]               w_size, w_aidx;
  logic [HW:0]                 w_inc;
  logic [MemoryElementWidth-1:0] w_rsp, w_ram_rdata;
  logic [c_aw-1:0]             w_addr;

  // ---------------- FSM ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = reset;
        if (req_valid && reset) w_next = ST_ACCESS;
      end
      ST_ACCESS: w_next = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // ---------------- request decode and checks ----------------
  always_comb begin
    // Out-of-range handles are steered to slot 0 but reported as not live.
    w_hok    = ({1'b0, r_array} < c_narrays);
    w_slot   = w_hok ? r_array : '0;
    w_live   = w_hok && r_live[w_slot];
    w_size   = r_size[w_slot];
    w_sp     = (r_top != '0) ? HW'(r_top - 1'b1) : '0;
    w_new_h  = (r_top != '0) ? r_stack[w_sp] : r_fresh[HW-1:0];
    w_inc    = r_in_use + 1'b1;
    w_err    = 1'b0;
    w_aidx   = r_index;
    w_mem_rd = 1'b0;
    w_mem_wr = 1'b0;
    w_rsp    = '0;
    case (r_op)
      OP_ALLOC: begin
        w_err = (r_top == '0) && (r_fresh >= c_narrays);
        w_rsp = MemoryElementWidth'(w_new_h);
      end
      OP_FREE:  w_err = !w_live;
      OP_READ: begin
        w_err    = !w_live || (r_index >= w_size);
        w_mem_rd = 1'b1;
      end
      OP_WRITE: begin
        w_err    = !w_live || (r_index >= c_narea);
        w_mem_wr = 1'b1;
      end
      OP_SIZE: begin
        w_err = !w_live;
        w_rsp = MemoryElementWidth'(w_size);
      end
      OP_PUSH: begin
        w_err    = !w_live || (w_size == c_narea);
        w_aidx   = w_size;
        w_mem_wr = 1'b1;
      end
      OP_POP: begin
        w_err    = !w_live || (w_size == '0);
        w_aidx   = w_size - 1'b1;
        w_mem_rd = 1'b1;
      end
      OP_RESIZE: w_err = !w_live || (r_index > c_narea);
      default: ;
    endcase
  end

  assign w_addr = c_aw'(w_slot) * c_aw'(NArea) + c_aw'(w_aidx);

  heap_ram #(
    .WIDTH  (MemoryElementWidth),
    .DEPTH  (c_depth),
    .ADDR_W (c_aw)
  ) u_ram (
    .clock (clock),
    .en    ((r_state == ST_ACCESS) && !w_err && (w_mem_rd || w_mem_wr)),
    .we    (w_mem_wr),
    .addr  (w_addr),
    .wdata (r_data),
    .rdata (w_ram_rdata)
  );

  // ---------------- request latch, counters, live bits ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_op        <= OP_ALLOC;
      r_array     <= '0;
      r_index     <= '0;
      r_data      <= '0;
      r_top       <= '0;
      r_fresh     <= '0;
      r_in_use    <= '0;
      r_allocs    <= '0;
      r_rsp_data  <= '0;
      r_rsp_error <= 1'b0;
      r_use_ram   <= 1'b0;
      for (int i = 0; i < NArrays; i++) r_live[i] <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && req_valid) begin
        r_op    <= heap_op_e'(req_op);
        r_array <= req_array;
        r_index <= req_index;
        r_data  <= req_data;
      end
      if (r_state == ST_ACCESS) begin
        r_rsp_error <= w_err;
        r_rsp_data  <= w_err ? '0 : w_rsp;
        r_use_ram   <= !w_err && (r_op == OP_READ || r_op == OP_POP);
        if (!w_err) begin
          case (r_op)
            OP_ALLOC: begin
              r_live[w_new_h] <= 1'b1;
              if (r_top != '0) r_top   <= r_top - 1'b1;
              else             r_fresh <= r_fresh + 1'b1;
              r_in_use <= w_inc;
              if (w_inc > r_allocs) r_allocs <= w_inc;
            end
            OP_FREE: begin
              r_live[w_slot] <= 1'b0;
              r_top          <= r_top + 1'b1;
              r_in_use       <= r_in_use - 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Sizes and stack slots are only read when live / below top, so no reset.
  always_ff @(posedge clock) begin
    if (r_state == ST_ACCESS && !w_err) begin
      case (r_op)
        OP_ALLOC:  r_size[w_new_h] <= '0;
        OP_FREE:   r_stack[r_top[HW-1:0]] <= r_array;
        OP_WRITE:  if (r_index >= w_size) r_size[w_slot] <= r_index + 1'b1;
        OP_PUSH:   r_size[w_slot] <= w_size + 1'b1;
        OP_POP:    r_size[w_slot] <= w_size - 1'b1;
        OP_RESIZE: r_size[w_slot] <= r_index;
        default: ;
      endcase
    end
  end

  assign rsp_data  = rsp_valid ? (r_use_ram ? w_ram_rdata : r_rsp_data) : '0;
  assign rsp_error = rsp_valid && r_rsp_error;
  assign in_use    = r_in_use;
  assign allocs    = r_allocs;

endmodule

`default_nettype wire

// File: tb/tb_array_heap.sv
// ============================================================================
// tb_array_heap : randomized scoreboard bench for array_heap
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_array_heap;

  localparam int W     = 12;
  localparam int NAREA = 10;
  localparam int NA    = 5;
  localparam int HW    = 3;
  localparam int IW    = 4;

  localparam logic [2:0] ALLOC = 3'd0, FREE = 3'd1, READ = 3'd2, WRITE = 3'd3,
                         SIZE  = 3'd4, PUSH = 3'd5, POP  = 3'd6, RESIZE = 3'd7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_op = '0;
  logic [HW-1:0] req_array = '0;
  logic [IW-1:0] req_index = '0;
  logic [W-1:0]  req_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [W-1:0]  rsp_data;
  logic          rsp_error;
  logic [HW:0]   in_use, allocs;

  array_heap #(.MemoryElementWidth(W), .NArea(NAREA), .NArrays(NA)) dut (
    .clock(clk), .reset(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_array(req_array), .req_index(req_index), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_error(rsp_error), .in_use(in_use), .allocs(allocs)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;  // 0 always ready, 1 random, 2 never

  typedef struct {
    bit          err;
    logic [W-1:0] data;
    bit          cd;
    int          inu;
    int          alc;
  } exp_t;
  exp_t sb[$];

  // Reference model: per-handle arrays plus a LIFO of freed handles.
  bit          m_live  [8];
  int          m_size  [8];
  logic [W-1:0] m_mem  [8][NAREA];
  bit          m_known [8][NAREA];
  int          m_freed[$];
  int          m_fresh = 0, m_in_use = 0, m_allocs = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_live[i] = 1'b0;
    m_freed.delete();
    m_fresh = 0; m_in_use = 0; m_allocs = 0;
  endfunction

  function automatic exp_t model(input logic [2:0] op, input int h, input int idx, input logic [W-1:0] d);
    exp_t e;
    bit lv;
    int nh;
    e.err = 1'b0; e.data = '0; e.cd = 1'b1;
    lv = (h < NA) && m_live[h];
    case (op)
      ALLOC: begin
        if (m_freed.size() > 0) nh = m_freed.pop_back();
        else if (m_fresh < NA) begin nh = m_fresh; m_fresh++; end
        else nh = -1;
        if (nh < 0) e.err = 1'b1;
        else begin
          m_live[nh] = 1'b1; m_size[nh] = 0; m_in_use++;
          if (m_in_use > m_allocs) m_allocs = m_in_use;
          e.data = W'(nh);
        end
      end
      FREE: begin
        e.err = !lv;
        if (lv) begin m_live[h] = 1'b0; m_freed.push_back(h); m_in_use--; end
      end
      READ: begin
        e.err = !lv || idx >= m_size[h];
        if (!e.err) begin e.data = m_mem[h][idx]; e.cd = m_known[h][idx]; end
      end
      WRITE: begin
        e.err = !lv || idx >= NAREA;
        if (!e.err) begin
          m_mem[h][idx] = d; m_known[h][idx] = 1'b1;
          if (idx >= m_size[h]) m_size[h] = idx + 1;
        end
      end
      SIZE: begin
        e.err = !lv;
        if (lv) e.data = W'(m_size[h]);
      end
      PUSH: begin
        e.err = !lv || m_size[h] == NAREA;
        if (!e.err) begin
          m_mem[h][m_size[h]] = d; m_known[h][m_size[h]] = 1'b1; m_size[h]++;
        end
      end
      POP: begin
        e.err = !lv || m_size[h] == 0;
        if (!e.err) begin
          m_size[h]--; e.data = m_mem[h][m_size[h]]; e.cd = m_known[h][m_size[h]];
        end
      end
      default: begin
        e.err = !lv || idx > NAREA;
        if (!e.err) m_size[h] = idx;
      end
    endcase
    e.inu = m_in_use;
    e.alc = m_allocs;
    return e;
  endfunction

  task automatic issue(input logic [2:0] op, input int h, input int idx, input int d);
    int n = 0;
    sb.push_back(model(op, h, idx, W'(d)));
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_array = HW'(h); req_index = IW'(idx); req_data = W'(d);
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 100) begin chk("req_ready_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk("drain_left", sb.size(), 0);
  endtask

  // rsp_ready driver
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = ($urandom_range(0, 3) != 0);
      default: rsp_ready = 1'b0;
    endcase
  end

  // Monitor: compares each accepted response against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
        if (sb.size() == 0) chk("unexpected_rsp", 1, 0);
        else begin
          e = sb.pop_front();
          chk("rsp_error", int'(rsp_error), int'(e.err));
          if (e.cd) chk("rsp_data", int'(rsp_data), int'(e.data));
          chk("in_use", int'(in_use), e.inu);
          chk("allocs", int'(allocs), e.alc);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, h, idx, n;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_data", int'(rsp_data), 0);
    chk("rst_rsp_error", int'(rsp_error), 0);
    chk("rst_in_use", int'(in_use), 0);
    chk("rst_allocs", int'(allocs), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", int'(req_ready), 1);

    // Directed sequence
    repeat (3) issue(ALLOC, 0, 0, 0);
    issue(WRITE, 0, 0, 1); issue(WRITE, 0, 1, 2); issue(WRITE, 0, 2, 3);
    issue(SIZE, 0, 0, 0); issue(READ, 0, 1, 0); issue(READ, 0, 3, 0); issue(SIZE, 0, 0, 0);
    issue(FREE, 1, 0, 0); issue(FREE, 0, 0, 0);
    issue(ALLOC, 0, 0, 0); issue(ALLOC, 0, 0, 0);
    issue(FREE, 1, 0, 0); issue(FREE, 1, 0, 0); issue(ALLOC, 0, 0, 0);
    for (int i = 0; i < 11; i++) issue(PUSH, 1, 0, 100 + i);
    issue(POP, 1, 0, 0); issue(SIZE, 1, 0, 0);
    issue(RESIZE, 1, 11, 0); issue(RESIZE, 1, 0, 0); issue(POP, 1, 0, 0);
    repeat (3) issue(ALLOC, 0, 0, 0);
    issue(READ, 5, 0, 0); issue(READ, 7, 0, 0); issue(FREE, 6, 0, 0);
    drain();
    chk("full_in_use", int'(in_use), m_in_use);
    chk("full_allocs", int'(allocs), m_allocs);

    // Randomized phase
    ready_mode = 1;
    for (int i = 0; i < 400; i++) begin
      op  = $urandom_range(0, 9);
      if (op > 7) op = (op == 8) ? PUSH : ALLOC;
      h   = ($urandom_range(0, 9) < 9) ? $urandom_range(0, NA - 1) : $urandom_range(NA, 7);
      idx = $urandom_range(0, 11);
      issue(3'(op), h, idx, $urandom_range(0, 4095));
    end
    drain();

    // Hold the response, then reset in the middle of it
    ready_mode = 2;
    repeat (2) @(posedge clk);
    issue(ALLOC, 0, 0, 0);
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      chk("hold_rsp_valid", int'(rsp_valid), 1);
      chk("hold_rsp_data", int'(rsp_data), int'(sb[0].data));
      chk("hold_rsp_error", int'(rsp_error), int'(sb[0].err));
      chk("hold_req_ready", int'(req_ready), 0);
      @(negedge clk);
    end
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", int'(rsp_valid), 0);
    chk("midrst_in_use", int'(in_use), 0);
    chk("midrst_allocs", int'(allocs), 0);
    chk("midrst_req_ready", int'(req_ready), 0);
    sb.delete();
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    ready_mode = 0;
    issue(ALLOC, 0, 0, 0);
    issue(ALLOC, 0, 0, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
